// File: rtl/base_pkg.sv
// Shared types and helpers for the base_abuf elastic buffer family.
package base_pkg;

  localparam int BASE_ABUF_MAX_DEPTH = 256;

  // Wide enough to address every entry of the deepest legal buffer.
  typedef logic [7:0] base_ptr_t;

  function automatic int base_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/base_abuf_ptr.sv
// Mod-depth wrapping pointer; advances one entry per inc, no power-of-2 assumption.
module base_abuf_ptr
  import base_pkg::*;
#(
  parameter int depth = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  output base_ptr_t ptr
);

  localparam base_ptr_t last = base_ptr_t'(depth - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == last) ? '0 : ptr + 8'd1;
    end
  end

endmodule

// File: rtl/base_abuf.sv
// Multi-entry elastic buffer on a valid/ready stream; ready, valid, count and almost-full are all registered.
// Optional macro BASE_ABUF_DQ_EN zeroes o_d while the buffer is empty.
module base_abuf
  import base_pkg::*;
#(
  parameter int width     = 1,
  parameter int depth     = 2,
  parameter int afull_lvl = 1,
  localparam int cw       = base_cw(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic [0:width-1] i_d,
  output logic             i_r,
  output logic             o_v,
  output logic [0:width-1] o_d,
  input  logic             o_r,
  output logic [0:cw-1]    o_cnt,
  output logic             o_afull
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cw-1:0] full_lvl = cw'(depth);
  localparam logic [cw-1:0] afull_th = cw'(depth - afull_lvl);

  logic [cw-1:0]    count;
  logic [cw-1:0]    count_nxt;
  logic             rdy_q;
  logic             vld_q;
  logic             afull_q;
  logic             push;
  logic             pop;
  base_ptr_t        wr_ptr;
  base_ptr_t        rd_ptr;
  logic [width-1:0] mem [depth];

  // Reset gates ready directly so no beat is accepted while the buffer is being flushed.
  assign i_r  = rdy_q & ~reset;
  assign push = i_v & i_r;
  assign pop  = vld_q & o_r;

  base_abuf_ptr #(.depth(depth)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  base_abuf_ptr #(.depth(depth)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[aw-1:0]] <= i_d;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags are derived from count_nxt so they settle in the same cycle as the count itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      count   <= count_nxt;
      rdy_q   <= (count_nxt != full_lvl);
      vld_q   <= (count_nxt != '0);
      afull_q <= (count_nxt >= afull_th);
    end
  end

  assign o_v     = vld_q;
  assign o_cnt   = count;
  assign o_afull = afull_q;

`ifdef BASE_ABUF_DQ_EN
  assign o_d = vld_q ? mem[rd_ptr[aw-1:0]] : '0;
`else
  assign o_d = mem[rd_ptr[aw-1:0]];
`endif

endmodule

// File: tb/tb_base_abuf.sv
// Bench for base_abuf: vector table on a depth-4 instance, streaming run on a depth-3 instance.
module tb_base_abuf;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       iv4 = 1'b0, or4 = 1'b0, ir4, ov4, af4;
  logic [7:0] d4 = '0, od4;
  logic [2:0] cnt4;

  logic       iv3 = 1'b0, or3 = 1'b0, ir3, ov3, af3;
  logic [7:0] d3 = '0, od3;
  logic [1:0] cnt3;

  int checks = 0;
  int errors = 0;

  logic [7:0] q4[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  base_abuf #(.width(8), .depth(4), .afull_lvl(1)) dut4 (
    .clk(clk), .reset(reset), .i_v(iv4), .i_d(d4), .i_r(ir4),
    .o_v(ov4), .o_d(od4), .o_r(or4), .o_cnt(cnt4), .o_afull(af4)
  );

  base_abuf #(.width(8), .depth(3), .afull_lvl(1)) dut3 (
    .clk(clk), .reset(reset), .i_v(iv3), .i_d(d3), .i_r(ir3),
    .o_v(ov3), .o_d(od3), .o_r(or3), .o_cnt(cnt3), .o_afull(af3)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic       chk;
    logic       er;
    logic       ev;
    logic [2:0] ec;
    logic       ea;
    logic       dchk;
    logic [7:0] ed;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] d,
                              input logic orr, input logic chk, input logic er,
                              input logic ev, input logic [2:0] ec, input logic ea);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.orr = orr; v.chk = chk;
    v.er = er; v.ev = ev; v.ec = ec; v.ea = ea;
    v.dchk = 1'b0; v.ed = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string nm, inout logic [7:0] q[$], input logic [7:0] act);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: got beat %0h expected no beat", nm, act);
    end else begin
      logic [7:0] e;
      e = q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got beat %0h expected %0h", nm, act, e);
      end
    end
  endtask

  initial begin
    int pops3;
    //              rst iv  d      or  chk ir ov cnt af
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    // fill to full with o_r held low
    tbl[2]  = mk(0, 1, 8'h11, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 8'h22, 0, 1, 1, 1, 1, 0);
    tbl[4]  = mk(0, 1, 8'h33, 0, 1, 1, 1, 2, 0);
    tbl[5]  = mk(0, 1, 8'h44, 0, 1, 1, 1, 3, 1);
    tbl[6]  = mk(0, 1, 8'h55, 0, 1, 0, 1, 4, 1);
    tbl[6].dchk = 1'b1; tbl[6].ed = 8'h11;
    // drain; ready returns one cycle after the first pop
    tbl[7]  = mk(0, 0, 8'h00, 1, 1, 0, 1, 4, 1);
    tbl[8]  = mk(0, 0, 8'h00, 1, 1, 1, 1, 3, 1);
    tbl[9]  = mk(0, 0, 8'h00, 1, 1, 1, 1, 2, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 0);
    tbl[11] = mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0);
    // simultaneous push/pop at count 2
    tbl[12] = mk(0, 1, 8'hA1, 0, 1, 1, 0, 0, 0);
    tbl[13] = mk(0, 1, 8'hA2, 0, 1, 1, 1, 1, 0);
    tbl[14] = mk(0, 1, 8'hA3, 1, 1, 1, 1, 2, 0);
    tbl[15] = mk(0, 0, 8'h00, 0, 1, 1, 1, 2, 0);
    tbl[15].dchk = 1'b1; tbl[15].ed = 8'hA2;
    // reset mid-stream at count 3 with valid and ready both high
    tbl[16] = mk(0, 1, 8'hB1, 0, 1, 1, 1, 2, 0);
    tbl[17] = mk(0, 0, 8'h00, 0, 1, 1, 1, 3, 1);
    tbl[18] = mk(1, 1, 8'hC1, 1, 1, 0, 1, 3, 1);
    tbl[19] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 0);
    tbl[20] = mk(0, 1, 8'hD1, 1, 1, 1, 0, 0, 0);
    tbl[21] = mk(0, 0, 8'h00, 1, 1, 1, 1, 1, 0);
    tbl[22] = mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0);
`ifdef BASE_ABUF_DQ_EN
    tbl[11].dchk = 1'b1; tbl[11].ed = 8'h00;
    tbl[22].dchk = 1'b1; tbl[22].ed = 8'h00;
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      iv4   = tbl[i].iv;
      d4    = tbl[i].d;
      or4   = tbl[i].orr;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("i_r[%0d]", i), 32'(ir4), 32'(tbl[i].er));
        chk($sformatf("o_v[%0d]", i), 32'(ov4), 32'(tbl[i].ev));
        chk($sformatf("o_cnt[%0d]", i), 32'(cnt4), 32'(tbl[i].ec));
        chk($sformatf("o_afull[%0d]", i), 32'(af4), 32'(tbl[i].ea));
      end
      if (tbl[i].dchk) chk($sformatf("o_d[%0d]", i), 32'(od4), 32'(tbl[i].ed));
      if (tbl[i].rst) begin
        q4.delete();
      end else begin
        if (ov4 && or4) sb_pop($sformatf("sb4[%0d]", i), q4, od4);
        if (iv4 && ir4) q4.push_back(d4);
      end
    end
    chk("sb4 residue", 32'(q4.size()), 32'd0);

    // streaming through depth 3: 20 beats, several pointer wraps
    pops3 = 0;
    iv4 = 1'b0; or4 = 1'b0;
    for (int n = 0; n < 23; n++) begin
      @(negedge clk);
      iv3 = (n < 20);
      d3  = 8'(n);
      or3 = 1'b1;
      #1;
      if (n >= 1 && n <= 20) begin
        chk($sformatf("stream cnt[%0d]", n), 32'(cnt3), 32'd1);
        chk($sformatf("stream o_v[%0d]", n), 32'(ov3), 32'd1);
        chk($sformatf("stream i_r[%0d]", n), 32'(ir3), 32'd1);
        chk($sformatf("stream afull[%0d]", n), 32'(af3), 32'd0);
      end
      if (ov3 && or3) begin
        sb_pop($sformatf("sb3[%0d]", n), q3, od3);
        pops3++;
      end
      if (iv3 && ir3) q3.push_back(d3);
    end
    chk("stream pops", 32'(pops3), 32'd20);
    chk("stream end cnt", 32'(cnt3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
